exec_unit: RTL
==============

# exec_unit

Parametrised integer execute unit: decodes ALU control fields (including the RV32M extension) and performs the selected operation on XLEN-bit operands. Sits in EX, fed by the main decoder's ALUOp/funct fields and the register-file operands. Single-cycle ops and iterative multiply/divide all return through the same valid/ready result port.

## Interface
- XLEN, 32, operand/result width; must be a power of two ≥ 8.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of any in-flight op.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request; high exactly when state is IDLE.
- ALUOp  in  2  00 add, 01 sub, 10 decode funct fields, 11 add.
- funct3  in  3  instruction funct3.
- funct75  in  1  instruction bit 30 (sub/sra select).
- funct70  in  1  instruction bit 25 (M-extension select).
- OPCode5  in  1  opcode bit 5 (1 = R-type).
- src_a, src_b  in  XLEN  operands; shifts use src_b[log2(XLEN)-1:0].
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.
- zero  out  1  registered (result == 0).
- illegal  out  1  registered; op not supported in this build.

## Operation
- Decode (ALUOp=10, M-op when OPCode5=1 and funct70=1): funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Decode (ALUOp=10, otherwise): 000 SUB if OPCode5&funct75 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct75 else SRL; 110 OR; 111 AND.
- Arithmetic modulo 2^XLEN; SLT/SLTU result is zero-extended 0/1.
- States: IDLE, MUL, DIV, DONE. Accept = in_valid & in_ready; operands and decoded op captured on accept.
- IDLE→DONE on accept of a single-cycle op or a special-case divide; IDLE→MUL / IDLE→DIV on accept of a multiply / normal divide.
- MUL: radix-2 shift-add on magnitudes, 2·XLEN product, XLEN iterations, sign fix-up on exit; MUL returns low half, MULH/MULHSU/MULHU high half (signed×signed, signed×unsigned, unsigned×unsigned).
- DIV: restoring divider on magnitudes, XLEN iterations; quotient sign = sign(a)^sign(b), remainder sign = sign(a) (signed ops only).
- Divide special cases, no iteration: divisor 0 → quotient all-ones, remainder = src_a; signed overflow (most-negative / −1) → quotient = most-negative, remainder 0.
- MUL/DIV→DONE after final iteration. DONE→IDLE when out_ready. out_valid high exactly in DONE.
- Reset values: state IDLE, out_valid 0, in_ready 1, result 0, zero 1, illegal 0.
- flush (any state): next state IDLE, out_valid drops next cycle, result discarded; flush outranks a same-cycle accept and a same-cycle out_ready.
- Reset mid-operation: immediate return to reset values, no result produced.

## Timing
- Accept in cycle T. Single-cycle ops and divide special cases: out_valid at T+1.
- MUL and normal DIV: iterations T+1..T+XLEN, out_valid at T+XLEN+1 (T+33 for XLEN=32).
- result/zero/illegal stable while out_valid & !out_ready; no new accept until DONE is left.
- Back-to-back single-cycle ops: one accept per two cycles (DONE must return to IDLE).
- in_ready is a combinational function of state only; never depends on in_valid.

## Configuration
- EXEC_DIV_EN defined: DIV/DIVU/REM/REMU execute as above; illegal always 0.
- EXEC_DIV_EN undefined: divider logic removed; divide ops go IDLE→DONE in one cycle with result 0, zero 1, illegal 1. MUL ops unaffected.

## Test plan
- ALUOp=10, funct3=000, OPCode5=1, a=5, b=7: funct75=0 → result 12 at T+1; funct75=1 → 0xFFFFFFFE, zero=0.
- funct3=101, a=0x80000000, b=4: funct75=1 → 0xF8000000; funct75=0 → 0x08000000; b=36 shifts by 4 identically.
- M-op a=0xFFFFFFFF, b=2: MUL → 0xFFFFFFFE, MULH → 0xFFFFFFFF, MULHU → 0x00000001, each with out_valid first at T+33.
- DIV a=100, b=0 → 0xFFFFFFFF at T+1; REM → 100; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; DIV −7/2 → 0xFFFFFFFD at T+33, REM → 0xFFFFFFFF.
- out_ready held low 3 cycles after out_valid: result stable, in_ready 0; release → in_ready 1 next cycle. Without EXEC_DIV_EN: DIVU 10/3 → result 0, illegal 1 at T+1.
- flush at T+10 of a DIV → out_valid never rises, in_ready 1 at T+11; rst_n low mid-MUL → out_valid 0, result 0, in_ready 1 immediately.

Source files
------------

// File: rtl/exec_unit_if.sv
// Request/response bundle of the execute unit: operands and ALU control in,
// result with zero/illegal flags out, valid/ready handshake in both directions.
interface exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic            funct75;
  logic            funct70;
  logic            OPCode5;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, ALUOp, funct3, funct75, funct70, OPCode5, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, ALUOp, funct3, funct75, funct70, OPCode5, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/exec_unit.sv
// Integer execute unit: RV32I ALU ops in one cycle, RV32M multiply/divide iterated
// one bit per cycle. Define EXEC_DIV_EN to build the divider; otherwise divides flag illegal.
module exec_unit #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  exec_unit_if.slave  bus
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e          state, state_nx;
  op_e             op_dec, op_q;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] acc, q, mb;
  logic            neg_q;
  logic            res_we, ill_nx;
  logic [XLEN-1:0] res_nx, alu_res;

  // ---------------------------------------------------------------- decode
  always_comb begin
    op_dec = OP_ADD;
    case (bus.ALUOp)
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        if (bus.OPCode5 && bus.funct70) begin
          case (bus.funct3)
            3'b000: op_dec = OP_MUL;
            3'b001: op_dec = OP_MULH;
            3'b010: op_dec = OP_MULHSU;
            3'b011: op_dec = OP_MULHU;
            3'b100: op_dec = OP_DIV;
            3'b101: op_dec = OP_DIVU;
            3'b110: op_dec = OP_REM;
            3'b111: op_dec = OP_REMU;
          endcase
        end else begin
          case (bus.funct3)
            3'b000: op_dec = (bus.OPCode5 && bus.funct75) ? OP_SUB : OP_ADD;
            3'b001: op_dec = OP_SLL;
            3'b010: op_dec = OP_SLT;
            3'b011: op_dec = OP_SLTU;
            3'b100: op_dec = OP_XOR;
            3'b101: op_dec = bus.funct75 ? OP_SRA : OP_SRL;
            3'b110: op_dec = OP_OR;
            3'b111: op_dec = OP_AND;
          endcase
        end
      end
      default: op_dec = OP_ADD;
    endcase
  end

  logic            is_mul_dec, is_div_dec, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [SHW-1:0]  shamt;

  // Iterative units work on magnitudes; the sign is re-applied on the last step.
  assign is_mul_dec = op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign is_div_dec = op_dec inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign a_sgn      = op_dec inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_sgn      = op_dec inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg      = a_sgn & bus.src_a[XLEN-1];
  assign b_neg      = b_sgn & bus.src_b[XLEN-1];
  assign mag_a      = a_neg ? -bus.src_a : bus.src_a;
  assign mag_b      = b_neg ? -bus.src_b : bus.src_b;
  assign shamt      = bus.src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_dec)
      OP_ADD:  alu_res = bus.src_a + bus.src_b;
      OP_SUB:  alu_res = bus.src_a - bus.src_b;
      OP_SLL:  alu_res = bus.src_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.src_a < bus.src_b)};
      OP_XOR:  alu_res = bus.src_a ^ bus.src_b;
      OP_SRL:  alu_res = bus.src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.src_a) >>> shamt);
      OP_OR:   alu_res = bus.src_a | bus.src_b;
      OP_AND:  alu_res = bus.src_a & bus.src_b;
      default: alu_res = '0;
    endcase
  end

  // ------------------------------------------------------------ multiplier
  // {acc, q} is the running product; the multiplier drains out of q's LSB.
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_acc_nx, mul_q_nx, mul_out;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign mul_sum    = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
  assign mul_acc_nx = mul_sum[XLEN:1];
  assign mul_q_nx   = {mul_sum[0], q[XLEN-1:1]};
  assign prod       = {mul_acc_nx, mul_q_nx};
  assign prod_fix   = neg_q ? -prod : prod;
  assign mul_out    = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

`ifdef EXEC_DIV_EN
  // --------------------------------------------------------------- divider
  // Restoring divide: acc is the partial remainder, q shifts dividend out / quotient in.
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            rem_neg_q, div_zero, div_ovf, div_special, div_ge;
  logic [XLEN-1:0] spec_res, div_acc_nx, div_q_nx, quot, remv, div_out;
  logic [XLEN:0]   div_sh;

  assign div_zero    = (bus.src_b == '0);
  assign div_ovf     = (op_dec inside {OP_DIV, OP_REM}) && (bus.src_a == MIN_NEG) && (bus.src_b == '1);
  assign div_special = div_zero | div_ovf;
  assign spec_res    = (op_dec inside {OP_REM, OP_REMU}) ? (div_zero ? bus.src_a : '0)
                                                         : (div_zero ? '1 : MIN_NEG);

  assign div_sh     = {acc, q[XLEN-1]};
  assign div_ge     = (div_sh >= {1'b0, mb});
  assign div_acc_nx = div_ge ? (div_sh[XLEN-1:0] - mb) : div_sh[XLEN-1:0];
  assign div_q_nx   = {q[XLEN-2:0], div_ge};
  assign quot       = neg_q ? -div_q_nx : div_q_nx;
  assign remv       = rem_neg_q ? -div_acc_nx : div_acc_nx;
  assign div_out    = (op_q inside {OP_REM, OP_REMU}) ? remv : quot;
`endif

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked assignment is non-blocking so all registers sample the same pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    // NOTE: each output of this block is given a default first, so no path can infer a latch.
    state_nx = state;
    res_we   = 1'b0;
    res_nx   = '0;
    ill_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (is_mul_dec) begin
            state_nx = S_MUL;
          end else if (is_div_dec) begin
`ifdef EXEC_DIV_EN
            if (div_special) begin
              state_nx = S_DONE;
              res_we   = 1'b1;
              res_nx   = spec_res;
            end else begin
              state_nx = S_DIV;
            end
`else
            state_nx = S_DONE;
            res_we   = 1'b1;
            ill_nx   = 1'b1;
`endif
          end else begin
            state_nx = S_DONE;
            res_we   = 1'b1;
            res_nx   = alu_res;
          end
        end
      end
      S_MUL: begin
        if (cnt == LAST) begin
          state_nx = S_DONE;
          res_we   = 1'b1;
          res_nx   = mul_out;
        end
      end
      S_DIV: begin
`ifdef EXEC_DIV_EN
        if (cnt == LAST) begin
          state_nx = S_DONE;
          res_we   = 1'b1;
          res_nx   = div_out;
        end
`else
        state_nx = S_IDLE;
`endif
      end
      S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Abort wins over any accept, iteration step or consumer handshake.
    if (flush) begin
      state_nx = S_IDLE;
      res_we   = 1'b0;
    end
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_ADD;
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      mb          <= '0;
      neg_q       <= 1'b0;
`ifdef EXEC_DIV_EN
      rem_neg_q   <= 1'b0;
`endif
      bus.result  <= '0;
      bus.zero    <= 1'b1;
      bus.illegal <= 1'b0;
    end else begin
      if (res_we) begin
        bus.result  <= res_nx;
        bus.zero    <= (res_nx == '0);
        bus.illegal <= ill_nx;
      end
      if (!flush) begin
        case (state)
          S_IDLE: begin
            if (bus.in_valid) begin
              op_q      <= op_dec;
              cnt       <= '0;
              acc       <= '0;
              q         <= mag_a;
              mb        <= mag_b;
              neg_q     <= a_neg ^ b_neg;
`ifdef EXEC_DIV_EN
              rem_neg_q <= a_neg;
`endif
            end
          end
          S_MUL: begin
            acc <= mul_acc_nx;
            q   <= mul_q_nx;
            cnt <= cnt + 1'b1;
          end
`ifdef EXEC_DIV_EN
          S_DIV: begin
            acc <= div_acc_nx;
            q   <= div_q_nx;
            cnt <= cnt + 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);

endmodule
